// File: rtl/cs_approx_pkg.sv
// cs_approx_pkg: shared widths, window depth, divisor and window type for the approximate-average filter
package cs_approx_pkg;
  localparam int DW  = 8;
  localparam int N   = 9;
  localparam int OW  = 10;
  localparam int SW  = 12;
  localparam int DIV = 9;
  typedef logic [N-1:0][DW-1:0] win_t;
endpackage

// File: rtl/cs_appr_sel.sv
// cs_appr_sel: combinational A=floor(s/9) and Xa=largest window entry <= A (in: win, s; out: a, xa)
module cs_appr_sel
  import cs_approx_pkg::*;
(
  input  win_t          win,
  input  logic [SW-1:0] s,
  output logic [DW-1:0] a,
  output logic [DW-1:0] xa
);
  always_comb begin
    a = DW'(s / SW'(DIV));
    xa = '0;
    for (int i = 0; i < N; i++) xa = (win[i] <= a && win[i] > xa) ? win[i] : xa;
  end
endmodule

// File: rtl/cs_approx_avg.sv
// cs_approx_avg: 9-tap approximate-average filter (in: clk, reset active-low async, X; out: Y registered, valid when CS_OUT_VALID_EN)
module cs_approx_avg
  import cs_approx_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] X,
`ifdef CS_OUT_VALID_EN
  output logic          valid,
`endif
  output logic [OW-1:0] Y
);
  win_t          win_q, win_d;
  logic [SW-1:0] s;
  logic [DW-1:0] a, xa;
  logic [SW:0]   t;
  logic [OW-1:0] y_q, y_d;
  cs_appr_sel u_sel (
    .win(win_d),
    .s  (s),
    .a  (a),
    .xa (xa)
  );
  always_comb begin
    win_d = {win_q[N-2:0], X};
    s = '0;
    for (int i = 0; i < N; i++) s = s + SW'(win_d[i]);
    t = {1'b0, s} + (SW+1)'(DIV) * (SW+1)'(xa);
    y_d = OW'(t >> 3);
  end
  always_comb assert (xa <= a);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      win_q <= '0;
      y_q <= '0;
    end else begin
      win_q <= win_d;
      y_q <= y_d;
    end
  assign Y = y_q;
`ifdef CS_OUT_VALID_EN
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  always_comb begin
    cnt_d = (cnt_q == 4'(N)) ? cnt_q : cnt_q + 4'd1;
    valid_d = cnt_d == 4'(N);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  assign valid = valid_q;
`endif
endmodule

// File: tb/tb_cs_approx_avg.sv
// tb_cs_approx_avg: scoreboard bench for cs_approx_avg with directed spot checks
module tb_cs_approx_avg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] X = '0;
  logic [9:0] Y;
`ifdef CS_OUT_VALID_EN
  logic       valid;
`endif
  cs_approx_avg dut (
    .clk  (clk),
    .reset(reset),
    .X    (X),
`ifdef CS_OUT_VALID_EN
    .valid(valid),
`endif
    .Y    (Y)
  );
  typedef struct {
    logic [9:0] y;
    logic       v;
  } exp_t;
  exp_t q[$];
  int   m_w[9];
  int   m_cnt;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (Y !== e.y) begin
        failures++;
        $display("FAIL scoreboard_y got=%0d want=%0d t=%0t", Y, e.y, $time);
      end
`ifdef CS_OUT_VALID_EN
      checks++;
      if (valid !== e.v) begin
        failures++;
        $display("FAIL scoreboard_valid got=%0b want=%0b t=%0t", valid, e.v, $time);
      end
`endif
    end
  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_w[i] = 0;
    m_cnt = 0;
    q.delete();
  endtask
  function automatic int model_y();
    int s, a, xa;
    bit found;
    s = 0;
    for (int i = 0; i < 9; i++) s += m_w[i];
    a = s / 9;
    xa = 0;
    found = 0;
    for (int v = a; v >= 0 && !found; v--)
      for (int i = 0; i < 9; i++)
        if (m_w[i] == v) begin
          xa = v;
          found = 1;
        end
    return (s + 9 * xa) / 8;
  endfunction
  task automatic step(input logic [7:0] x);
    exp_t e;
    @(negedge clk);
    #1;
    X = x;
    for (int i = 8; i > 0; i--) m_w[i] = m_w[i-1];
    m_w[0] = int'(x);
    if (m_cnt < 9) m_cnt++;
    e.y = 10'(model_y());
    e.v = (m_cnt == 9);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] x, input int n);
    for (int i = 0; i < n; i++) step(x);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    X = 8'hAA;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Y !== 10'd0) begin
      failures++;
      $display("FAIL reset_y got=%0d want=0", Y);
    end
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b want=0", valid);
    end
`endif
    reset = 1'b1;
  endtask
  task automatic test_const();
    fill(8'h10, 8);
    checks++;
    if (Y !== 10'd16) begin
      failures++;
      $display("FAIL partial_fill got=%0d want=16", Y);
    end
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_early got=%0b want=0", valid);
    end
`endif
    step(8'h10);
    checks++;
    if (Y !== 10'h024) begin
      failures++;
      $display("FAIL const_10 got=%0d want=36", Y);
    end
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL valid_9th got=%0b want=1", valid);
    end
`endif
  endtask
  task automatic test_ramp();
    for (int i = 1; i <= 9; i++) step(8'(i));
    checks++;
    if (Y !== 10'h00B) begin
      failures++;
      $display("FAIL ramp got=%0d want=11", Y);
    end
  endtask
  task automatic test_max();
    fill(8'hFF, 9);
    checks++;
    if (Y !== 10'h23D) begin
      failures++;
      $display("FAIL max got=%0d want=573", Y);
    end
  endtask
  task automatic test_select();
    fill(8'h00, 8);
    step(8'd90);
    checks++;
    if (Y !== 10'h00B) begin
      failures++;
      $display("FAIL select got=%0d want=11", Y);
    end
  endtask
  task automatic test_impulse();
    fill(8'h10, 9);
    step(8'h19);
    checks++;
    if (Y !== 10'h025) begin
      failures++;
      $display("FAIL impulse got=%0d want=37", Y);
    end
    fill(8'h10, 8);
    checks++;
    if (Y !== 10'h025) begin
      failures++;
      $display("FAIL impulse_held got=%0d want=37", Y);
    end
    step(8'h10);
    checks++;
    if (Y !== 10'h024) begin
      failures++;
      $display("FAIL impulse_gone got=%0d want=36", Y);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 40; i++) step(8'($urandom_range(0, 255)));
  endtask
  task automatic test_async_reset();
    fill(8'h33, 4);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Y !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got=%0d want=0", Y);
    end
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL async_valid got=%0b want=0", valid);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    fill(8'h10, 8);
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL refill_valid_early got=%0b want=0", valid);
    end
`endif
    step(8'h10);
    checks++;
    if (Y !== 10'h024) begin
      failures++;
      $display("FAIL refill got=%0d want=36", Y);
    end
`ifdef CS_OUT_VALID_EN
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL refill_valid got=%0b want=1", valid);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_const();
    test_ramp();
    test_max();
    test_select();
    test_impulse();
    test_random();
    test_async_reset();
    fill(8'h00, 2);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cs_approx_avg.md
Name: cs_approx_avg

Overview:
- Streaming sliding-window smoothing filter over an 8-bit sample stream.
- Captures one sample per clock into a 9-deep window.
- From the window it computes the "approximate average", defined as the largest sample not exceeding the truncated mean.
- Outputs a registered 10-bit result each cycle; sits between a sample source and a result sink, with no handshake.

Parameters:
- DW, 8, sample width.
- N, 9, window depth. Fixed; the divisor-by-9 logic is sized for it.
- OW, 10, output width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- X  input  DW  sample; one new sample captured every rising edge, no valid qualifier.
- Y  output  OW  registered result.

Behaviour:
- Reset asserted (reset=0):
  - all 9 window entries, Y and the internal fill counter clear to 0 immediately, independent of clk;
  - Y holds 0 while reset is asserted.
- Window shift: each rising edge, window <= {X, w0..w7}; the oldest entry is dropped.
- Result computation uses the post-edge window (the captured X plus the previous 8 samples). It is computed combinationally from X and w0..w7 and registered into Y on the same edge, so Y reflects the window including the sample captured at that edge.
- Arithmetic, all unsigned with truncation, no rounding:
  - S = sum of the 9 window entries; 12 bits, max 2295.
  - A = floor(S/9); range 0..255. Implement as exact integer divide by constant, not by approximation.
  - Xa = max{ wi : wi <= A }. Always exists because min(wi) <= A. Equal values are permitted; Xa may equal A.
  - Y = floor((S + 9*Xa)/8). The 13-bit intermediate is shifted right by 3; max Y = 573, so it fits in 10 bits with no saturation.
- Latency: the first fully valid Y is present after the 9th rising edge following reset release.
- Before the window is full, the zero-filled entries participate normally. There is no special-casing; Y is computed and driven every cycle.
- Fill counter: saturates at 9, is used only by the optional feature, and has no effect on Y.
- Reset mid-stream: the window is flushed to zeros and refilling restarts from the next edge.
- Y is the direct output of a register with no combinational path to the port.

Optional Feature:
- Macro CS_OUT_VALID_EN.
- Defined: adds output port valid (1 bit, registered).
  - Reset value 0.
  - Asserted on the edge that captures the 9th sample after reset release; stays 1 until the next reset.
- Undefined: no valid port and no fill counter logic; Y behaviour is identical.

Decomposition:
- Package cs_approx_pkg: DW, N, OW, sum width (12), the constant divisor 9, and the window array typedef (N x DW).
- One sub-module, cs_appr_sel: pure combinational.
  - Inputs: window and S.
  - Outputs: A and Xa (compare-and-select tree).
- Top level holds the shift register, summation, final scale, Y register and the optional valid flag.

Test Plan:
- Reset, then 9 samples of 0x10: S=144, A=16, Xa=16 -> Y=0x024 (36) after the 9th edge.
- Samples 1,2,...,9: S=45, A=5, Xa=5 -> Y=0x00B (11).
- 9 samples of 0xFF: S=2295, A=255, Xa=255 -> Y=0x23D (573); checks max width, no overflow.
- 8 zeros then 90: S=90, A=10, Xa=0 -> Y=0x00B (11); checks the selection picks the largest entry <= A, not the nearest.
- Steady 0x10 stream, then one 0x19 (25): S=153, A=17, Xa=16 -> Y=0x025 (37).
  - Continue with 0x10: after 9 further edges Y returns to 0x024.
- Assert reset mid-stream asynchronously (between edges): Y=0 without a clock edge.
  - After release plus 9 samples of 0x10, Y=0x024.
  - With CS_OUT_VALID_EN: valid=0 until that 9th edge, then 1.
